simple_unit_with_param_hs_pipe: RTL and testbench
=================================================

Name: simple_unit_with_param_hs_pipe

Overview:
Parametrised successor of the simple width-parametrised pass-through unit. It carries a DATA_WIDTH-bit word from input channel a to output channel b through DEPTH registered, valid/ready-handshaked stages. It supports full backpressure and full throughput, and reports the number of words in flight. It is used as a configurable latency/retiming element between handshaked components in generated hierarchies.

Parameters:
DATA_WIDTH, 2, width of the data word in bits; legal range >= 1.
DEPTH, 2, number of register stages (latency in cycles); legal range 1..16. Any other value triggers a generate-time $error.
CNT_WIDTH, derived, $clog2(DEPTH+1); width of the occupancy output. Not overridable.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  synchronous reset, active-high.
a_data  input  DATA_WIDTH  input word.
a_vld  input  1  input word valid.
a_rd  output  1  block can accept an input word.
b_data  output  DATA_WIDTH  output word (stage DEPTH-1 register).
b_vld  output  1  output word valid.
b_rd  input  1  consumer accepts the output word.
occupancy  output  CNT_WIDTH  number of words held, 0..DEPTH.

Behaviour:
- Interface: one clock clk; rst is synchronous, active-high.
- Storage: stage i (0..DEPTH-1) holds vld[i] and data[i].
- Ready chain (combinational):
  - rdy[DEPTH] = b_rd.
  - rdy[i] = !vld[i] || rdy[i+1].
  - a_rd = rdy[0].
- Transfer: a transfer on a channel occurs when vld && rd are both 1 in the same cycle.
- Stage update on a clock edge where rdy[i] = 1:
  - stage 0 loads vld[0] <= a_vld, data[0] <= a_data.
  - stage i > 0 loads vld[i] <= vld[i-1], data[i] <= data[i-1].
  - When rdy[i] = 0, stage i holds its contents.
- Outputs: b_vld = vld[DEPTH-1], b_data = data[DEPTH-1]. Data is never modified.
- Latency: a word accepted at edge N into an empty pipe appears on b_vld/b_data after edge N+DEPTH-1, i.e. DEPTH cycles of register delay.
- Throughput: 1 word/cycle while b_rd = 1. A full pipe with b_rd = 1 accepts a new word in the same cycle, because ready propagates combinationally through the chain.
- Ordering: strict FIFO. No word is dropped or duplicated.
- Occupancy counter (registered):
  - +1 on an a-transfer only.
  - -1 on a b-transfer only.
  - unchanged when both or neither occur.
  - never exceeds DEPTH; never below 0.
  - equals the number of set vld[] bits at all times.
- Bubbles: a stage with vld = 0 is always overwritten on the next edge. Bubbles collapse when downstream is stalled.
- Reset, when rst = 1 at an edge:
  - all vld <= 0, data <= 0, occupancy <= 0. In-flight words are discarded.
  - Outputs after reset: b_vld = 0, b_data = 0, occupancy = 0, a_rd = 1.
  - While rst is high, a_rd still reflects the ready chain, but no transfer is committed.
- Boundaries:
  - Full (occupancy = DEPTH) with b_rd = 0 → a_rd = 0.
  - Empty → b_vld = 0 regardless of b_rd.
  - a_vld = 1 with a_rd = 0 → the input word is not consumed; the source must hold it.
- DEPTH = 1 degenerates to a single handshaked register with combinational ready passthrough.

Test Plan:
- Reset: DATA_WIDTH=8, DEPTH=4; hold rst 2 cycles → b_vld=0, b_data=0, occupancy=0, a_rd=1.
- Single word latency: drive a_data=0xA5 with a_vld=1 for one cycle, b_rd=1 → b_vld=1, b_data=0xA5 exactly 4 edges after acceptance, for 1 cycle; occupancy goes 1,1,1,1,0.
- Streaming: push 0x00..0x1F back-to-back with b_rd=1 → after 4-cycle fill, one word per cycle in order; a_rd stays 1; occupancy holds at 4.
- Backpressure fill: b_rd=0, push 0x10,0x11,0x12,0x13,0x14 → first four accepted, a_rd=0 while 0x14 is offered, occupancy=4. Then b_rd=1 for one cycle → 0x10 output and 0x14 accepted in the same cycle; occupancy stays 4.
- Random stall: random a_vld and b_rd at 50% each for 1000 words, across DEPTH in {1,3,16} and DATA_WIDTH in {1,2,32} → scoreboard matches in order; occupancy equals the scoreboard count every cycle.
- Mid-operation reset: with 3 words held, assert rst 1 cycle → next cycle b_vld=0, occupancy=0. A word pushed afterwards emerges after DEPTH cycles, and no pre-reset word appears.

Source files
------------

// File: rtl/simple_unit_with_param_hs_pipe.sv
// Parametrised valid/ready register pipeline: DEPTH handshaked stages from channel a to b,
// full throughput through a combinational ready chain, plus a registered occupancy count.
module simple_unit_with_param_hs_pipe #(
    parameter  int DATA_WIDTH = 2,
    parameter  int DEPTH      = 2,
    localparam int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] a_data,
    input  logic                  a_vld,
    output logic                  a_rd,
    output logic [DATA_WIDTH-1:0] b_data,
    output logic                  b_vld,
    input  logic                  b_rd,
    output logic [CNT_WIDTH-1:0]  occupancy
);

    if (DEPTH < 1 || DEPTH > 16) begin : g_bad_depth
        $error("simple_unit_with_param_hs_pipe: DEPTH must be in 1..16");
    end
    if (DATA_WIDTH < 1) begin : g_bad_width
        $error("simple_unit_with_param_hs_pipe: DATA_WIDTH must be >= 1");
    end

    logic [DEPTH-1:0]      vld_q, vld_d;
    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_d [DEPTH];
    logic [DEPTH-1:0]      src_vld;
    logic [DATA_WIDTH-1:0] src_data [DEPTH];
    logic [DEPTH-1:0]      rdy;
    logic [CNT_WIDTH-1:0]  occ_q, occ_d;
    logic                  a_fire;
    logic                  b_fire;

    // Each stage is fed from the stage before it; stage 0 is fed from channel a.
    for (genvar g = 0; g < DEPTH; g++) begin : g_src
        if (g == 0) begin : g_head
            assign src_vld[g]  = a_vld;
            assign src_data[g] = a_data;
        end else begin : g_body
            assign src_vld[g]  = vld_q[g-1];
            assign src_data[g] = data_q[g-1];
        end
    end

    // A stage can load when it or any stage downstream of it has a hole, or the sink takes
    // a word. Built as a running OR from the output end so no bit of rdy reads another.
    always_comb begin
        logic acc;
        // NOTE: blocking '=' in combinational logic so acc carries its new value to the
        // next loop iteration; '<=' is only ever used for flops.
        acc = b_rd;
        rdy = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            acc    = acc || !vld_q[i];
            rdy[i] = acc;
        end
    end

    // NOTE: every output of this block is given its hold value first, so a stage that is
    // not ready keeps its contents and no latch is inferred.
    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (rdy[i]) begin
                vld_d[i]  = src_vld[i];
                data_d[i] = src_data[i];
            end
        end
    end

    assign a_fire = a_vld && rdy[0];
    assign b_fire = vld_q[DEPTH-1] && b_rd;

    always_comb begin
        occ_d = occ_q;
        if (a_fire && !b_fire) begin
            occ_d = occ_q + 1'b1;
        end else if (b_fire && !a_fire) begin
            occ_d = occ_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            occ_q <= '0;
            // NOTE: the data registers are cleared as well, so b_data reads zero after
            // reset instead of leaking a discarded word.
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking '<=' for every flop so all stages shift on the same edge
            // using the values from before it.
            vld_q  <= vld_d;
            data_q <= data_d;
            occ_q  <= occ_d;
        end
    end

    assign a_rd      = rdy[0];
    assign b_vld     = vld_q[DEPTH-1];
    assign b_data    = data_q[DEPTH-1];
    assign occupancy = occ_q;

    // The counter is kept separately for timing; it must always agree with the valid bits.
    occupancy_matches_valids : assert property (
        @(posedge clk) disable iff (rst) int'(occ_q) == $countones(vld_q)
    );

endmodule

// File: tb/tb_simple_unit_with_param_hs_pipe.sv
// Directed checks on an 8-bit, 4-deep pipe plus randomised stall runs on three other
// parameter sets, each with an in-order scoreboard.
module tb_simple_unit_with_param_hs_pipe;

    logic       clk;
    logic       rst;
    logic       rnd_rst;
    logic [7:0] m_a_data;
    logic       m_a_vld;
    logic       m_a_rd;
    logic [7:0] m_b_data;
    logic       m_b_vld;
    logic       m_b_rd;
    logic [2:0] m_occ;

    int total = 0;
    int bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    simple_unit_with_param_hs_pipe #(
        .DATA_WIDTH(8),
        .DEPTH     (4)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .a_data   (m_a_data),
        .a_vld    (m_a_vld),
        .a_rd     (m_a_rd),
        .b_data   (m_b_data),
        .b_vld    (m_b_vld),
        .b_rd     (m_b_rd),
        .occupancy(m_occ)
    );

    initial begin
        rnd_rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rnd_rst = 1'b0;
    end

    // Random stall runs: (DW,DEPTH) = (1,1), (2,3), (32,16).
    for (genvar g = 0; g < 3; g++) begin : g_rnd
        localparam int DW = (g == 0) ? 1 : (g == 1) ? 2 : 32;
        localparam int DP = (g == 0) ? 1 : (g == 1) ? 3 : 16;
        localparam int CW = $clog2(DP + 1);

        logic [DW-1:0] a_data;
        logic [DW-1:0] b_data;
        logic          a_vld;
        logic          a_rd;
        logic          b_vld;
        logic          b_rd;
        logic [CW-1:0] occ;
        logic          done;
        logic [31:0]   sb [$];

        simple_unit_with_param_hs_pipe #(
            .DATA_WIDTH(DW),
            .DEPTH     (DP)
        ) u_rnd (
            .clk      (clk),
            .rst      (rnd_rst),
            .a_data   (a_data),
            .a_vld    (a_vld),
            .a_rd     (a_rd),
            .b_data   (b_data),
            .b_vld    (b_vld),
            .b_rd     (b_rd),
            .occupancy(occ)
        );

        initial begin
            int          sent;
            int          rcvd;
            logic        hold;
            logic [31:0] w;
            done   = 1'b0;
            a_vld  = 1'b0;
            b_rd   = 1'b0;
            a_data = '0;
            sent   = 0;
            rcvd   = 0;
            hold   = 1'b0;
            repeat (3) @(posedge clk);
            for (int cyc = 0; cyc < 20000 && rcvd < 1000; cyc++) begin
                @(negedge clk);
                if (!hold) begin
                    a_vld  = (sent < 1000) && ($urandom_range(0, 1) == 1);
                    a_data = DW'($urandom);
                end
                b_rd = ($urandom_range(0, 1) == 1);
                #1;
                check($sformatf("rnd%0d_occ", g), 32'(occ), 32'(sb.size()));
                if (b_vld && b_rd) begin
                    if (sb.size() == 0) begin
                        check($sformatf("rnd%0d_underflow", g), 32'(1), 32'(0));
                    end else begin
                        w = sb.pop_front();
                        check($sformatf("rnd%0d_data", g), 32'(b_data), w);
                    end
                    rcvd++;
                end
                if (a_vld && a_rd) begin
                    sb.push_back(32'(a_data));
                    sent++;
                end
                hold = a_vld && !a_rd;
            end
            check($sformatf("rnd%0d_words", g), 32'(rcvd), 32'(1000));
            a_vld = 1'b0;
            b_rd  = 1'b0;
            done  = 1'b1;
        end
    end

    initial begin
        int exp_acc;
        int exp_pop;
        rst      = 1'b1;
        m_a_vld  = 1'b0;
        m_a_data = 8'h00;
        m_b_rd   = 1'b0;

        // Reset held for two edges.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_b_vld", 32'(m_b_vld), 32'(0));
        check("rst_b_data", 32'(m_b_data), 32'(0));
        check("rst_occ", 32'(m_occ), 32'(0));
        check("rst_a_rd", 32'(m_a_rd), 32'(1));
        rst = 1'b0;

        // Single word: visible after the 4th edge counting the accepting edge.
        m_a_vld  = 1'b1;
        m_a_data = 8'hA5;
        m_b_rd   = 1'b1;
        check("one_a_rd", 32'(m_a_rd), 32'(1));
        @(posedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 0) m_a_vld = 1'b0;
            check($sformatf("one_occ_%0d", k), 32'(m_occ), (k < 4) ? 32'(1) : 32'(0));
            check($sformatf("one_b_vld_%0d", k), 32'(m_b_vld), (k == 3) ? 32'(1) : 32'(0));
            if (k == 3) check("one_b_data", 32'(m_b_data), 32'hA5);
            @(posedge clk);
        end

        // Streaming 0x00..0x1F with b_rd held high.
        for (int c = 0; c < 37; c++) begin
            @(negedge clk);
            exp_acc = (c < 32) ? c : 32;
            exp_pop = (c <= 4) ? 0 : ((c - 4 < 32) ? c - 4 : 32);
            check($sformatf("strm_occ_%0d", c), 32'(m_occ), 32'(exp_acc - exp_pop));
            check($sformatf("strm_b_vld_%0d", c), 32'(m_b_vld),
                  (c >= 4 && c < 36) ? 32'(1) : 32'(0));
            if (c >= 4 && c < 36) check($sformatf("strm_data_%0d", c), 32'(m_b_data), 32'(c - 4));
            m_a_vld  = (c < 32);
            m_a_data = 8'(c);
            if (c < 32) check($sformatf("strm_a_rd_%0d", c), 32'(m_a_rd), 32'(1));
            @(posedge clk);
        end

        // Backpressure fill, then one release cycle that pops and pushes together.
        m_b_rd = 1'b0;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            m_a_vld  = 1'b1;
            m_a_data = 8'h10 + 8'(j);
            check($sformatf("bp_a_rd_%0d", j), 32'(m_a_rd), 32'(1));
            @(posedge clk);
        end
        @(negedge clk);
        m_a_data = 8'h14;
        check("bp_full_a_rd", 32'(m_a_rd), 32'(0));
        check("bp_full_occ", 32'(m_occ), 32'(4));
        check("bp_full_b_vld", 32'(m_b_vld), 32'(1));
        check("bp_full_b_data", 32'(m_b_data), 32'h10);
        m_b_rd = 1'b1;
        #1;
        check("bp_pass_a_rd", 32'(m_a_rd), 32'(1));
        @(posedge clk);
        @(negedge clk);
        m_b_rd  = 1'b0;
        m_a_vld = 1'b0;
        check("bp_swap_occ", 32'(m_occ), 32'(4));
        check("bp_swap_b_data", 32'(m_b_data), 32'h11);
        m_b_rd = 1'b1;
        for (int j = 1; j < 5; j++) begin
            check($sformatf("drain_b_vld_%0d", j), 32'(m_b_vld), 32'(1));
            check($sformatf("drain_b_data_%0d", j), 32'(m_b_data), 32'h10 + 32'(j));
            @(posedge clk);
            @(negedge clk);
        end
        check("drain_empty_b_vld", 32'(m_b_vld), 32'(0));
        check("drain_empty_occ", 32'(m_occ), 32'(0));

        // Mid-operation reset with three words held.
        m_b_rd = 1'b0;
        for (int j = 0; j < 3; j++) begin
            m_a_vld  = 1'b1;
            m_a_data = 8'h21 + 8'(j);
            @(posedge clk);
            @(negedge clk);
        end
        m_a_vld = 1'b0;
        check("mr_held_occ", 32'(m_occ), 32'(3));
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("mr_b_vld", 32'(m_b_vld), 32'(0));
        check("mr_occ", 32'(m_occ), 32'(0));
        check("mr_a_rd", 32'(m_a_rd), 32'(1));
        check("mr_b_data", 32'(m_b_data), 32'(0));
        m_a_vld  = 1'b1;
        m_a_data = 8'h77;
        m_b_rd   = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 0) m_a_vld = 1'b0;
            check($sformatf("mr_post_b_vld_%0d", k), 32'(m_b_vld), (k == 3) ? 32'(1) : 32'(0));
            check($sformatf("mr_post_occ_%0d", k), 32'(m_occ), (k < 4) ? 32'(1) : 32'(0));
            if (k < 4) begin
                check($sformatf("mr_post_b_data_%0d", k), 32'(m_b_data),
                      (k == 3) ? 32'h77 : 32'(0));
            end
            @(posedge clk);
        end

        for (int i = 0; i < 30000 && !(g_rnd[0].done && g_rnd[1].done && g_rnd[2].done); i++) begin
            @(posedge clk);
        end
        check("rnd_all_done", 32'(g_rnd[0].done && g_rnd[1].done && g_rnd[2].done), 32'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
